// File: rtl/anton_neopixel_apb_bridge.sv
// APB3 slave bridge onto the NeoPixel raw controller's byte-wide bus.
// Each word-aligned APB transfer becomes one single-cycle busWrite or
// busRead strobe. Reads wait for the controller's registered data.
// Illegal addresses are answered with PSLVERR and are never forwarded.
`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 255
`endif

module anton_neopixel_apb_bridge #(
  parameter int BUFFER_END = `BUFFER_END_DEFAULT
) (
  input  logic        busClk,
  input  logic        busReset,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [15:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [13:0] busAddr,
  output logic [7:0]  busDataIn,
  output logic        busWrite,
  output logic        busRead,
  input  logic [7:0]  busDataOut
);

  localparam int BUFFER_BITS = $clog2(BUFFER_END + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WRITE     = 3'd1;
  localparam logic [2:0] S_READ      = 3'd2;
  localparam logic [2:0] S_READ_WAIT = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;

  logic [2:0]  r_state;
  logic [31:0] r_rdata;
  logic        r_ready;
  logic        r_slverr;
  logic [13:0] r_addr;
  logic [7:0]  r_din;
  logic        r_write;
  logic        r_read;

  logic [13:0] w_addr;
  logic        w_buf_err;
  logic        w_reg_err;
  logic        w_err;
  logic        w_setup;
  logic        w_unused;

  assign w_addr  = PADDR[15:2];
  assign w_setup = PSEL && !PENABLE;

  // Byte-index and data-lane bits the controller never sees.
  assign w_unused = &{1'b0, PADDR[1:0], PWDATA[31:8]};

  // Pixel buffer range check: any bit above the buffer index width, or an
  // in-width index past the last valid byte, is out of range.
  generate
    if (BUFFER_BITS < 13) begin : g_buf_narrow
      localparam logic [BUFFER_BITS-1:0] BUF_END_L = BUFFER_BITS'(BUFFER_END);
      assign w_buf_err = (w_addr[12:BUFFER_BITS] != '0) ||
                         (w_addr[BUFFER_BITS-1:0] > BUF_END_L);
    end else begin : g_buf_full
      assign w_buf_err = (w_addr[12:0] > 13'(BUFFER_END));
    end
  endgenerate

  // Control space holds only four registers (word index 0x2000..0x2003).
  assign w_reg_err = (w_addr[12:2] != '0);
  assign w_err     = w_addr[13] ? w_reg_err : w_buf_err;

  // Transfer sequencer: strobes, wait states and response are all registered.
  always_ff @(posedge busClk or posedge busReset) begin
    if (busReset) begin
      r_state  <= S_IDLE;
      r_rdata  <= '0;
      r_ready  <= 1'b0;
      r_slverr <= 1'b0;
      r_addr   <= '0;
      r_din    <= '0;
      r_write  <= 1'b0;
      r_read   <= 1'b0;
    end else begin
      r_write  <= 1'b0;
      r_read   <= 1'b0;
      r_ready  <= 1'b0;
      r_slverr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // An access phase without a preceding setup phase is ignored.
          if (w_setup) begin
            r_addr  <= w_addr;
            r_din   <= PWDATA[7:0];
            r_rdata <= '0;
            if (w_err) begin
              r_state  <= S_RESP;
              r_ready  <= 1'b1;
              r_slverr <= 1'b1;
            end else if (PWRITE) begin
              r_state <= S_WRITE;
              r_write <= 1'b1;
            end else begin
              r_state <= S_READ;
              r_read  <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (!PSEL) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_RESP;
            r_ready <= 1'b1;
          end
        end
        S_READ: begin
          r_state <= PSEL ? S_READ_WAIT : S_IDLE;
        end
        S_READ_WAIT: begin
          // Controller data is valid one cycle after the read strobe.
          if (!PSEL) begin
            r_state <= S_IDLE;
          end else begin
            r_rdata <= {24'b0, busDataOut};
            r_state <= S_RESP;
            r_ready <= 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign PRDATA    = r_rdata;
  assign PREADY    = r_ready;
  assign PSLVERR   = r_slverr;
  assign busAddr   = r_addr;
  assign busDataIn = r_din;
  assign busWrite  = r_write;
  assign busRead   = r_read;

endmodule

// File: tb/tb_anton_neopixel_apb_bridge.sv
// Directed bench for the NeoPixel APB bridge with a small registered-read
// model of the downstream controller and strobe counters.
`timescale 1ns/1ps

module tb_anton_neopixel_apb_bridge;

  logic        busClk;
  logic        busReset;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [13:0] busAddr;
  logic [7:0]  busDataIn;
  logic        busWrite;
  logic        busRead;
  logic [7:0]  busDataOut;

  logic [7:0]  rd_value;
  int          n_vec;
  int          n_err;
  int          wr_pulses;
  int          rd_pulses;
  int          both_high;
  int          wr_snap;
  int          rd_snap;

  anton_neopixel_apb_bridge #(.BUFFER_END(255)) dut (
    .busClk    (busClk),
    .busReset  (busReset),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .busAddr   (busAddr),
    .busDataIn (busDataIn),
    .busWrite  (busWrite),
    .busRead   (busRead),
    .busDataOut(busDataOut)
  );

  initial busClk = 1'b0;
  always #5 busClk = ~busClk;

  // Controller model: read data is registered off the read strobe, garbage otherwise.
  always @(posedge busClk) begin
    busDataOut <= (busRead === 1'b1) ? rd_value : 8'hA5;
  end

  // Strobe counters.
  always @(posedge busClk) begin
    if (busWrite === 1'b1) wr_pulses++;
    if (busRead === 1'b1) rd_pulses++;
    if (busWrite === 1'b1 && busRead === 1'b1) both_high++;
  end

  task automatic tick();
    @(posedge busClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic go_idle();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
  endtask

  // Legal write; returns at the start of the cycle after PREADY.
  task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    tick();
    chk("wr_strobe", {31'b0, busWrite}, 32'd1);
    chk("wr_no_read", {31'b0, busRead}, 32'd0);
    chk("wr_addr", {18'b0, busAddr}, {18'b0, a[15:2]});
    chk("wr_data", {24'b0, busDataIn}, {24'b0, d[7:0]});
    chk("wr_wait", {31'b0, PREADY}, 32'd0);
    PENABLE = 1'b1;
    tick();
    chk("wr_strobe_end", {31'b0, busWrite}, 32'd0);
    chk("wr_ready", {31'b0, PREADY}, 32'd1);
    chk("wr_slverr", {31'b0, PSLVERR}, 32'd0);
    tick();
  endtask

  // Legal read; returns at the start of the cycle after PREADY.
  task automatic apb_read(input logic [15:0] a, input logic [7:0] rv);
    rd_value = rv;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a; PWDATA = 32'h0;
    tick();
    chk("rd_strobe", {31'b0, busRead}, 32'd1);
    chk("rd_no_write", {31'b0, busWrite}, 32'd0);
    chk("rd_addr", {18'b0, busAddr}, {18'b0, a[15:2]});
    chk("rd_wait1", {31'b0, PREADY}, 32'd0);
    PENABLE = 1'b1;
    tick();
    chk("rd_strobe_end", {31'b0, busRead}, 32'd0);
    chk("rd_wait2", {31'b0, PREADY}, 32'd0);
    tick();
    chk("rd_ready", {31'b0, PREADY}, 32'd1);
    chk("rd_slverr", {31'b0, PSLVERR}, 32'd0);
    chk("rd_data", PRDATA, {24'b0, rv});
    tick();
  endtask

  // Illegal address: zero wait states, error response, no strobe.
  task automatic apb_err(input logic [15:0] a, input logic wr);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = 32'hFFFF_FFFF;
    tick();
    chk("err_ready", {31'b0, PREADY}, 32'd1);
    chk("err_slverr", {31'b0, PSLVERR}, 32'd1);
    chk("err_no_strobe", {30'b0, busWrite, busRead}, 32'd0);
    chk("err_prdata", PRDATA, 32'd0);
    PENABLE = 1'b1;
    tick();
    chk("err_done", {30'b0, PREADY, PSLVERR}, 32'd0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    wr_pulses = 0; rd_pulses = 0; both_high = 0;
    rd_value = 8'h00;
    busReset = 1'b1;
    go_idle();
    PADDR = 16'h0; PWDATA = 32'h0;

    // Reset state
    tick(); tick();
    chk("rst_ctrl", {28'b0, PREADY, PSLVERR, busWrite, busRead}, 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_addr", {18'b0, busAddr}, 32'd0);
    chk("rst_din", {24'b0, busDataIn}, 32'd0);
    busReset = 1'b0;
    tick();

    // Basic write: PADDR 0x0010 -> busAddr 4, data byte 0x5A
    wr_snap = wr_pulses;
    apb_write(16'h0010, 32'hDEADBE5A);
    go_idle();
    chk("wr_ready_drop", {31'b0, PREADY}, 32'd0);
    chk("wr_one_pulse", wr_pulses - wr_snap, 32'd1);

    // Control-register read: PADDR 0x8008 -> busAddr 0x2002
    rd_snap = rd_pulses;
    apb_read(16'h8008, 8'h15);
    go_idle();
    chk("rd_one_pulse", rd_pulses - rd_snap, 32'd1);

    // Error transfers: one past buffer end, control word index 4
    wr_snap = wr_pulses; rd_snap = rd_pulses;
    apb_err(16'h0400, 1'b1);
    go_idle();
    tick();
    apb_err(16'h8010, 1'b0);
    go_idle();
    tick();
    chk("err_no_pulses", (wr_pulses - wr_snap) + (rd_pulses - rd_snap), 32'd0);

    // Boundaries that are legal: last buffer byte and last control register
    apb_write(16'h03FC, 32'h0000_00C3);
    go_idle();
    apb_read(16'h800C, 8'h7E);
    go_idle();
    tick();

    // PSEL dropped during READ_WAIT: no PREADY, then a normal write
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 16'h0008;
    tick();
    PENABLE = 1'b1;
    tick();
    go_idle();
    tick();
    chk("abort_no_ready", {31'b0, PREADY}, 32'd0);
    tick();
    chk("abort_quiet", {29'b0, PREADY, busWrite, busRead}, 32'd0);
    apb_write(16'h0020, 32'h0000_0099);
    go_idle();

    // Asynchronous reset mid-READ_WAIT
    rd_snap = rd_pulses;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 16'h8004; rd_value = 8'h33;
    tick();
    PENABLE = 1'b1;
    tick();
    busReset = 1'b1;
    #1;
    chk("arst_ctrl", {28'b0, PREADY, PSLVERR, busWrite, busRead}, 32'd0);
    chk("arst_addr", {18'b0, busAddr}, 32'd0);
    chk("arst_prdata", PRDATA, 32'd0);
    tick();
    busReset = 1'b0;
    // Access phase still held with no fresh setup: must be ignored
    tick(); tick(); tick();
    chk("arst_no_ready", {31'b0, PREADY}, 32'd0);
    chk("arst_one_read", rd_pulses - rd_snap, 32'd1);
    go_idle();
    tick();

    // Eight back-to-back writes to buffer bytes 0..7
    wr_snap = wr_pulses; rd_snap = rd_pulses;
    for (int i = 0; i < 8; i++) begin
      apb_write(16'(4 * i), 32'(8'h10 + i));
    end
    go_idle();
    tick();
    chk("b2b_writes", wr_pulses - wr_snap, 32'd8);
    chk("b2b_no_reads", rd_pulses - rd_snap, 32'd0);
    chk("never_both", both_high, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
